// File: rtl/fifo_uart_tx_if.sv
// ============================================================================
// Module   : fifo_uart_tx_if
// Brief    : FIFO read port plus serial-line signals of the UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tx_enable;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic                  tx;
    logic                  busy;
    logic                  frame_done;

    modport master (
        input  tx_enable, fifo_empty, fifo_data,
        output fifo_rd_en, tx, busy, frame_done
    );

    modport slave (
        output tx_enable, fifo_empty, fifo_data,
        input  fifo_rd_en, tx, busy, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// ============================================================================
// Module   : fifo_uart_tx
// Brief    : UART serializer draining a synchronous FIFO, LSB first, 8N1 style.
//            Define UART_TX_PARITY_EN to insert an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  wire            clk,
    input  wire            rst_n,
    fifo_uart_tx_if.master bus
);

    localparam int c_BAUD_W  = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_MAX = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
    localparam int c_BIT_W   = (c_BIT_MAX > 1) ? $clog2(c_BIT_MAX) : 1;

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0]  c_DATA_LAST = c_BIT_W'(DATA_WIDTH - 1);
    localparam logic [c_BIT_W-1:0]  c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_tx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [c_BAUD_W-1:0]   r_baud;
    logic [c_BIT_W-1:0]    r_bit_cnt;

    state_t                w_state;
    logic                  w_tx;
    logic [DATA_WIDTH-1:0] w_shift;
    logic [c_BAUD_W-1:0]   w_baud;
    logic [c_BIT_W-1:0]    w_bit_cnt;
    logic                  w_rd_en;
    logic                  w_bit_end;
    logic                  w_frame_done;

`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
    logic                  w_parity;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_shift   <= '0;
            r_baud    <= '0;
            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state;
            r_tx      <= w_tx;
            r_shift   <= w_shift;
            r_baud    <= w_baud;
            r_bit_cnt <= w_bit_cnt;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity;
`endif
        end
    end

    always_comb begin
        w_rd_en      = (r_state == S_IDLE) && bus.tx_enable && !bus.fifo_empty && rst_n;
        w_bit_end    = (r_baud == c_BAUD_LAST);
        w_state      = r_state;
        w_tx         = r_tx;
        w_shift      = r_shift;
        w_baud       = r_baud;
        w_bit_cnt    = r_bit_cnt;
        w_frame_done = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity     = r_parity;
`endif

        // Baud counter only runs while a bit is on the line.
        if (r_state != S_IDLE && r_state != S_FETCH) begin
            w_baud = w_bit_end ? '0 : r_baud + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_tx = 1'b1;
                if (w_rd_en) begin
                    w_state = S_FETCH;
                end
            end
            S_FETCH: begin
                w_shift   = bus.fifo_data;
                w_tx      = 1'b0;
                w_baud    = '0;
                w_bit_cnt = '0;
`ifdef UART_TX_PARITY_EN
                w_parity  = ^bus.fifo_data;
`endif
                w_state   = S_START;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_tx      = r_shift[0];
                    w_shift   = r_shift >> 1;
                    w_bit_cnt = '0;
                    w_state   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == c_DATA_LAST) begin
                        w_bit_cnt = '0;
`ifdef UART_TX_PARITY_EN
                        w_tx      = r_parity;
                        w_state   = S_PARITY;
`else
                        w_tx      = 1'b1;
                        w_state   = S_STOP;
`endif
                    end else begin
                        w_tx      = r_shift[0];
                        w_shift   = r_shift >> 1;
                        w_bit_cnt = r_bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_tx      = 1'b1;
                    w_bit_cnt = '0;
                    w_state   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == c_STOP_LAST) begin
                        w_frame_done = 1'b1;
                        w_bit_cnt    = '0;
                        w_state      = S_IDLE;
                    end else begin
                        w_bit_cnt = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_tx    = 1'b1;
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.tx         = r_tx;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.frame_done = w_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// ============================================================================
// Module   : tb_fifo_uart_tx
// Brief    : Drives two transmitters (1 and 2 stop bits) from FIFO models and
//            checks every cycle against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_uart_tx;

    localparam int c_CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int c_PAR = 1;
`else
    localparam int c_PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic tx_enable;
    logic [7:0] mem [0:1023];
    int wp = 0;
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transmitted bit sequence of one frame; bit i of the result is line bit i.
    function automatic logic [15:0] frame_vec(input logic [7:0] d, input int sb);
        logic [15:0] v;
        v = '1;
        v[0] = 1'b0;
        for (int i = 0; i < 8; i++) v[1+i] = d[i];
        if (c_PAR == 1) v[9] = ^d;
        for (int s = 0; s < sb; s++) v[9+c_PAR+s] = 1'b1;
        return v;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_ch
        localparam int SB = k + 1;
        fifo_uart_tx_if #(.DATA_WIDTH(8)) bus ();
        logic [7:0]  fdata = 8'h00;
        int          rp = 0;
        int          pops = 0;
        logic [3:0]  exp_q[$];
        logic [3:0]  e;
        logic [3:0]  act;
        logic [15:0] fv;
        int          nb;
        int          run = 0;
        int          cyc = 0;
        int          fdc = 0;
        int          last_len = 0;
        int          last_fdc = 0;
        logic [15:0] vec = '0;
        logic [15:0] last_vec = '0;

        assign bus.tx_enable  = tx_enable;
        assign bus.fifo_empty = (rp == wp);
        assign bus.fifo_data  = fdata;

        fifo_uart_tx #(
            .DATA_WIDTH  (8),
            .CLKS_PER_BIT(c_CPB),
            .STOP_BITS   (SB)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );

        // FIFO read port; data_out carries junk except right after a pop.
        always @(posedge clk) begin
            if (bus.fifo_rd_en) begin
                fdata <= mem[rp];
                rp    <= rp + 1;
                pops  <= pops + 1;
            end else begin
                fdata <= 8'($urandom);
            end
        end

        always @(negedge clk) begin
            act = {bus.tx, bus.busy, bus.frame_done, bus.fifo_rd_en};
            if (!rst_n) begin
                chk($sformatf("rst_out%0d", k), act, 4'b1000);
                exp_q.delete();
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("frame_out%0d", k), act, e);
            end else begin
                e = {1'b1, 1'b0, 1'b0, tx_enable && (rp != wp)};
                chk($sformatf("idle_out%0d", k), act, e);
                if (e[0]) begin
                    fv = frame_vec(mem[rp], SB);
                    nb = 9 + c_PAR + SB;
                    exp_q.push_back(4'b1100);
                    for (int b = 0; b < nb; b++)
                        for (int c = 0; c < c_CPB; c++)
                            exp_q.push_back({fv[b], 1'b1, (b == nb-1) && (c == c_CPB-1), 1'b0});
                end
            end

            // Trace of the most recent frame, sampled mid-bit.
            if (!rst_n) begin
                run = 0;
            end else if (bus.busy) begin
                if (run == 0) begin
                    run = 1; cyc = 0; vec = '0; fdc = 0;
                end else begin
                    cyc++;
                end
                if (cyc >= 1 && ((cyc - 1) % c_CPB) == 2 && ((cyc - 1) / c_CPB) < 16)
                    vec[(cyc - 1) / c_CPB] = bus.tx;
                if (bus.frame_done) fdc++;
            end else if (run != 0) begin
                run = 0;
                last_len = cyc + 1;
                last_vec = vec;
                last_fdc = fdc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wp] = d;
        wp++;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((g_ch[0].bus.busy || g_ch[1].bus.busy ||
                g_ch[0].rp != wp || g_ch[1].rp != wp) && t < 5000) begin
            tick();
            t++;
        end
        repeat (2) tick();
        if (t >= 5000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", t);
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("async_rst0", {g_ch[0].bus.tx, g_ch[0].bus.busy, g_ch[0].bus.frame_done, g_ch[0].bus.fifo_rd_en}, 4'b1000);
        chk("async_rst1", {g_ch[1].bus.tx, g_ch[1].bus.busy, g_ch[1].bus.frame_done, g_ch[1].bus.fifo_rd_en}, 4'b1000);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base0;
        int base1;
        int t;

        rst_n = 1'b0;
        tx_enable = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tx_enable = 1'b1;

        // Empty FIFO: idle line, no pops.
        repeat (100) tick();
        chk("idle_pops", g_ch[0].pops + g_ch[1].pops, 0);
        reset_pulse();
        tick();

        // Single 0xA5 frame.
        base0 = g_ch[0].pops;
        base1 = g_ch[1].pops;
        push(8'hA5);
        wait_idle();
        chk("a5_bits0", g_ch[0].last_vec, (c_PAR == 1) ? 16'h054A : 16'h034A);
        chk("a5_bits1", g_ch[1].last_vec, (c_PAR == 1) ? 16'h0D4A : 16'h074A);
        chk("a5_len0", g_ch[0].last_len, (c_PAR == 1) ? 45 : 41);
        chk("a5_len1", g_ch[1].last_len, (c_PAR == 1) ? 49 : 45);
        chk("a5_done0", g_ch[0].last_fdc, 1);
        chk("a5_done1", g_ch[1].last_fdc, 1);
        chk("a5_pops0", g_ch[0].pops - base0, 1);

        // Back-to-back stream.
        base0 = g_ch[0].pops;
        base1 = g_ch[1].pops;
        push(8'h00); push(8'hFF); push(8'h3C);
        wait_idle();
        chk("b2b_pops0", g_ch[0].pops - base0, 3);
        chk("b2b_pops1", g_ch[1].pops - base1, 3);
        chk("b2b_last0", g_ch[0].last_vec, (c_PAR == 1) ? 16'h0478 : 16'h0278);

        // tx_enable dropped mid-frame.
        base0 = g_ch[0].pops;
        base1 = g_ch[1].pops;
        push(8'h5A); push(8'hC3);
        t = 0;
        while (g_ch[0].pops == base0 && t < 50) begin tick(); t++; end
        repeat (1 + c_CPB + 3 * c_CPB + 1) tick();
        tx_enable = 1'b0;
        repeat (120) tick();
        chk("hold_pops0", g_ch[0].pops - base0, 1);
        chk("hold_pops1", g_ch[1].pops - base1, 1);
        chk("hold_busy", {g_ch[0].bus.busy, g_ch[1].bus.busy}, 2'b00);
        tx_enable = 1'b1;
        wait_idle();
        chk("resume_pops0", g_ch[0].pops - base0, 2);

        // Parity position: bit 9 is parity when enabled, otherwise a stop bit.
        push(8'h07);
        wait_idle();
        chk("bit9_07", g_ch[0].last_vec[9], 1'b1);
        push(8'h03);
        wait_idle();
        chk("bit9_03", g_ch[0].last_vec[9], (c_PAR == 1) ? 1'b0 : 1'b1);

        // Abandon a frame with reset.
        push(8'h96);
        repeat (20) tick();
        reset_pulse();
        wait_idle();

        // Randomized traffic, enable toggling and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 47) == 0 && wp < 1000) push(8'($urandom));
            if ($urandom_range(0, 23) == 0) tx_enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 999) == 0) reset_pulse();
        end
        tx_enable = 1'b1;
        wait_idle();
        chk("final_drain", {g_ch[0].rp == wp, g_ch[1].rp == wp}, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
UART transmit serializer placed directly downstream of the team's synchronous FIFO buffer. It pops words from the FIFO read port (rd_en / empty / registered data_out, one-cycle read latency) and shifts each word out on a single serial line. Frame format: 8N1 by default, with a configurable stop-bit count and optional parity. It provides back-to-back streaming with a fixed inter-frame gap.

Parameters:
DATA_WIDTH, 8, word width; must match the FIFO DATA_WIDTH.
CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 2.
STOP_BITS, 1, number of stop bits; legal values are 1 and 2.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
tx_enable  input  1  permits new frames to start; does not abort a frame in flight
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_WIDTH  FIFO data_out; valid on the cycle after a rd_en pulse
fifo_rd_en  output  1  FIFO pop request, combinational
tx  output  1  serial line, registered, idle high
busy  output  1  high from FETCH through the end of the last stop bit
frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Reset, asynchronous and active-low, gives: state=IDLE, tx=1, busy=0, frame_done=0, shift register=0, counters=0. fifo_rd_en=0 while rst_n=0.
- fifo_rd_en = (state==IDLE) && tx_enable && !fifo_empty && rst_n. It is never asserted in any other state, so it pops at most one word per frame.
- States: IDLE -> FETCH -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: tx=1. If fifo_rd_en=1, go to FETCH on the next edge.
- FETCH: lasts one cycle while FIFO data_out updates.
  - On the exit edge: shift_reg<=fifo_data, tx<=0, baud_cnt<=0, go to START.
- Each bit period holds tx for exactly CLKS_PER_BIT cycles.
  - baud_cnt runs 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - The bit advances on the edge where baud_cnt==CLKS_PER_BIT-1.
- START: tx=0 for one bit period, then tx<=shift_reg[0] and go to DATA.
- DATA: bits are sent LSB first.
  - shift_reg shifts right at each bit advance.
  - bit_cnt runs 0..DATA_WIDTH-1.
  - After bit DATA_WIDTH-1: go to PARITY if enabled, else STOP with tx<=1.
- STOP: tx=1 for STOP_BITS bit periods.
  - frame_done=1 on the final cycle of the final stop bit.
  - Next state is IDLE.
- Latency and timing:
  - fifo_rd_en is high in cycle N; tx goes low at the edge ending cycle N+1.
  - Frame length, measured from the start-bit edge: (1+DATA_WIDTH+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
- Back-to-back streaming: after STOP the block spends one IDLE cycle (rd_en) and one FETCH cycle. The inter-frame gap is therefore exactly 2 extra tx-high cycles beyond the stop bits.
- busy is 0 in IDLE and 1 in every other state.
- Boundary conditions:
  - fifo_empty=1 in IDLE: stay idle, tx=1, no pop.
  - The FIFO goes empty mid-frame: no effect on the current frame.
  - tx_enable drops mid-frame: the current frame completes, then the block idles.
  - tx_enable drops in the IDLE cycle that would pop: no pop occurs.
  - rst_n asserted mid-frame: immediate return to the reset values; tx goes high asynchronously and the partial frame is abandoned. The popped word is lost.
  - fifo_data is sampled only on the FETCH exit edge and ignored at all other times.

Optional Feature:
UART_TX_PARITY_EN
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - Parity lasts one bit period with tx = even parity, i.e. the XOR of all DATA_WIDTH data bits, computed from fifo_data at load time and stored in a register.
  - Frame length gains one bit period.
- Undefined: no PARITY state or parity register; DATA goes directly to STOP.

Test Plan:
1. Reset with the FIFO empty, then run 100 cycles -> tx=1, busy=0, fifo_rd_en=0 throughout. Assert rst_n=0 mid-run -> outputs take the reset values immediately.
2. CLKS_PER_BIT=4, STOP_BITS=1, no parity. Push 0xA5, tx_enable=1 -> exactly one rd_en pulse; tx falls 2 edges later. Over 40 cycles tx = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. frame_done pulses once at cycle 40; busy spans 41 cycles (FETCH plus frame).
3. Push 0x00, 0xFF, 0x3C back-to-back -> three correct frames, each separated by exactly 2 extra high cycles, with exactly 3 rd_en pulses. fifo_rd_en is never asserted while busy=1.
4. Drop tx_enable at data bit 3 with 2 words queued -> the current frame completes and no further pop occurs. Raising tx_enable resumes with the next word.
5. Set STOP_BITS=2 -> the stop phase lasts 8 cycles at CLKS_PER_BIT=4 and frame_done pulses only at its end.
6. With UART_TX_PARITY_EN, send 0x07 -> parity bit = 1; send 0x03 -> parity bit = 0. Frame = 44 cycles at CLKS_PER_BIT=4.
